// File: rtl/dch_dcb_ssd_if.sv
// ----------------------------------------------------------------------------
// dch_dcb_ssd_if
// Purpose : bundles the switch, LED and seven-segment signals of the
//           dch_dcb_ssd down-counter display block.
// Signals : hex_en / bcd_en / sel         switch side, driven by the board
//           rst_led / hex_en_led /
//           bcd_en_led / sel_led          LED mirrors of the switches
//           zero_led                      registered "selected counter == 0"
//           cc[6:0]                       cathodes, active low, bit0=a..bit6=g
//           an_on / an_off[6:0]           anode drives (one digit on)
// Modports: master = board/stimulus side, slave = display block.
// ----------------------------------------------------------------------------
interface dch_dcb_ssd_if;
   logic       dch_dcb_ssd_hex_en;
   logic       dch_dcb_ssd_bcd_en;
   logic       dch_dcb_ssd_sel;
   logic       dch_dcb_ssd_rst_led;
   logic       dch_dcb_ssd_hex_en_led;
   logic       dch_dcb_ssd_bcd_en_led;
   logic       dch_dcb_ssd_sel_led;
   logic       dch_dcb_ssd_zero_led;
   logic [6:0] dch_dcb_ssd_cc;
   logic       dch_dcb_ssd_an_on;
   logic [6:0] dch_dcb_ssd_an_off;

   modport master (
      output dch_dcb_ssd_hex_en, dch_dcb_ssd_bcd_en, dch_dcb_ssd_sel,
      input  dch_dcb_ssd_rst_led, dch_dcb_ssd_hex_en_led, dch_dcb_ssd_bcd_en_led,
             dch_dcb_ssd_sel_led, dch_dcb_ssd_zero_led, dch_dcb_ssd_cc,
             dch_dcb_ssd_an_on, dch_dcb_ssd_an_off
   );

   modport slave (
      input  dch_dcb_ssd_hex_en, dch_dcb_ssd_bcd_en, dch_dcb_ssd_sel,
      output dch_dcb_ssd_rst_led, dch_dcb_ssd_hex_en_led, dch_dcb_ssd_bcd_en_led,
             dch_dcb_ssd_sel_led, dch_dcb_ssd_zero_led, dch_dcb_ssd_cc,
             dch_dcb_ssd_an_on, dch_dcb_ssd_an_off
   );
endinterface

// File: rtl/dch_dcb_ssd.sv
// ----------------------------------------------------------------------------
// dch_dcb_ssd
// Purpose : hex (F..0) and BCD (9..0) down counters stepped by a shared clock
//           divider; one of them is selected and shown on a single seven-segment
//           digit through a registered encoder. Switches are mirrored to LEDs.
// Ports   : dch_dcb_ssd_clk  system clock, rising edge
//           dch_dcb_ssd_rst  synchronous, active-high reset
//           bus              dch_dcb_ssd_if.slave (switches, LEDs, cathodes, anodes)
// Params  : clk_counter_value  divider terminal count; counters step once per
//                              (clk_counter_value+1) clocks
// Config  : DCH_DCB_SSD_ZERO_HOLD_EN  when defined, a counter that reaches 0
//           stays at 0 until reset instead of wrapping.
// ----------------------------------------------------------------------------
module dch_dcb_ssd #(
   parameter int clk_counter_value = 0
) (
   input  logic          dch_dcb_ssd_clk,
   input  logic          dch_dcb_ssd_rst,
   dch_dcb_ssd_if.slave  bus
);

   localparam int DIV_W = (clk_counter_value > 0) ? $clog2(clk_counter_value + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(clk_counter_value);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [3:0]       hex_cnt;
   logic [3:0]       bcd_cnt;
   logic [3:0]       hex_nxt;
   logic [3:0]       bcd_nxt;
   logic [3:0]       sel_cnt;
   logic [6:0]       cc_q;
   logic             zero_q;

   // Active-low cathode pattern, bit0=a .. bit6=g.
   function automatic logic [6:0] seg(input logic [3:0] v);
      case (v)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
   endfunction

   // Divider free-runs independent of the enables.
   assign tick = (div_cnt == DIV_TC);

   always_ff @(posedge dch_dcb_ssd_clk) begin
      if (dch_dcb_ssd_rst) div_cnt <= '0;
      else if (tick)       div_cnt <= '0;
      else                 div_cnt <= div_cnt + DIV_W'(1);
   end

   // Next-step values for each counter (applied only on tick & enable).
   always_comb begin
      hex_nxt = hex_cnt - 4'd1;
      if (bcd_cnt == 4'd0 || bcd_cnt > 4'd9) bcd_nxt = 4'd9;  // illegal A..F recovers to 9
      else                                   bcd_nxt = bcd_cnt - 4'd1;
`ifdef DCH_DCB_SSD_ZERO_HOLD_EN
      if (hex_cnt == 4'd0) hex_nxt = 4'd0;
      if (bcd_cnt == 4'd0) bcd_nxt = 4'd0;
`endif
   end

   always_ff @(posedge dch_dcb_ssd_clk) begin
      if (dch_dcb_ssd_rst) begin
         hex_cnt <= 4'hF;
         bcd_cnt <= 4'h9;
      end else begin
         if (tick && bus.dch_dcb_ssd_hex_en) hex_cnt <= hex_nxt;
         if (tick && bus.dch_dcb_ssd_bcd_en) bcd_cnt <= bcd_nxt;
      end
   end

   // Registered display: shows the counter value one clock after it changes.
   assign sel_cnt = bus.dch_dcb_ssd_sel ? bcd_cnt : hex_cnt;

   always_ff @(posedge dch_dcb_ssd_clk) begin
      if (dch_dcb_ssd_rst) begin
         cc_q   <= 7'b1111111;
         zero_q <= 1'b0;
      end else begin
         cc_q   <= seg(sel_cnt);
         zero_q <= (sel_cnt == 4'd0);
      end
   end

   assign bus.dch_dcb_ssd_cc         = cc_q;
   assign bus.dch_dcb_ssd_zero_led   = zero_q;
   assign bus.dch_dcb_ssd_rst_led    = dch_dcb_ssd_rst;
   assign bus.dch_dcb_ssd_hex_en_led = bus.dch_dcb_ssd_hex_en;
   assign bus.dch_dcb_ssd_bcd_en_led = bus.dch_dcb_ssd_bcd_en;
   assign bus.dch_dcb_ssd_sel_led    = bus.dch_dcb_ssd_sel;
   assign bus.dch_dcb_ssd_an_on      = 1'b0;
   assign bus.dch_dcb_ssd_an_off     = 7'b1111111;

endmodule

// File: tb/tb_dch_dcb_ssd.sv
// ----------------------------------------------------------------------------
// tb_dch_dcb_ssd
// Two instances (divider terminal count 0 and 3) driven by the same switches,
// each compared every clock against a value-level model: counters as plain
// integers, divider phase as "clocks since reset modulo period".
// ----------------------------------------------------------------------------
module tb_dch_dcb_ssd;

   logic clk = 1'b0;
   logic rst, hex_en, bcd_en, sel;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dch_dcb_ssd_if u_if0 ();
   dch_dcb_ssd_if u_if1 ();

   assign u_if0.dch_dcb_ssd_hex_en = hex_en;
   assign u_if0.dch_dcb_ssd_bcd_en = bcd_en;
   assign u_if0.dch_dcb_ssd_sel    = sel;
   assign u_if1.dch_dcb_ssd_hex_en = hex_en;
   assign u_if1.dch_dcb_ssd_bcd_en = bcd_en;
   assign u_if1.dch_dcb_ssd_sel    = sel;

   dch_dcb_ssd #(.clk_counter_value(0)) u_dut0 (
      .dch_dcb_ssd_clk (clk),
      .dch_dcb_ssd_rst (rst),
      .bus             (u_if0)
   );

   dch_dcb_ssd #(.clk_counter_value(3)) u_dut1 (
      .dch_dcb_ssd_clk (clk),
      .dch_dcb_ssd_rst (rst),
      .bus             (u_if1)
   );

   // Reference model state, index 0/1 = instance
   int         period [2];
   int         m_hex  [2];
   int         m_bcd  [2];
   int         m_since[2];
   logic [6:0] m_cc   [2];
   logic       m_zero [2];
   logic [6:0] seg_tbl[16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model across one rising edge with the currently driven inputs.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_hex[d] = 15; m_bcd[d] = 9; m_since[d] = 0;
            m_cc[d] = 7'h7F; m_zero[d] = 1'b0;
         end else begin
            int  v;
            bit  tk;
            v = sel ? m_bcd[d] : m_hex[d];
            m_cc[d]   = seg_tbl[v];
            m_zero[d] = (v == 0);
            tk = ((m_since[d] % period[d]) == period[d] - 1);
            if (tk && hex_en) begin
`ifdef DCH_DCB_SSD_ZERO_HOLD_EN
               if (m_hex[d] != 0) m_hex[d] = m_hex[d] - 1;
`else
               m_hex[d] = (m_hex[d] + 15) % 16;
`endif
            end
            if (tk && bcd_en) begin
`ifdef DCH_DCB_SSD_ZERO_HOLD_EN
               if (m_bcd[d] != 0) m_bcd[d] = m_bcd[d] - 1;
`else
               m_bcd[d] = (m_bcd[d] == 0) ? 9 : m_bcd[d] - 1;
`endif
            end
            m_since[d]++;
         end
      end
   endtask

   // Called on a falling edge: drive, check mirrors, clock, check registered outputs.
   task automatic step(input logic r, input logic h, input logic b, input logic s);
      rst = r; hex_en = h; bcd_en = b; sel = s;
      #1;
      chk("rst_led0", u_if0.dch_dcb_ssd_rst_led, r);
      chk("hex_en_led1", u_if1.dch_dcb_ssd_hex_en_led, h);
      chk("bcd_en_led0", u_if0.dch_dcb_ssd_bcd_en_led, b);
      chk("sel_led1", u_if1.dch_dcb_ssd_sel_led, s);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("cc0",   u_if0.dch_dcb_ssd_cc,       m_cc[0]);
      chk("zero0", u_if0.dch_dcb_ssd_zero_led, m_zero[0]);
      chk("cc1",   u_if1.dch_dcb_ssd_cc,       m_cc[1]);
      chk("zero1", u_if1.dch_dcb_ssd_zero_led, m_zero[1]);
      chk("an_on0",  u_if0.dch_dcb_ssd_an_on,  1'b0);
      chk("an_off1", u_if1.dch_dcb_ssd_an_off, 7'h7F);
   endtask

   initial begin
      logic h, b, s;
      period[0] = 1;
      period[1] = 4;
      seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      rst = 1'b1; hex_en = 1'b0; bcd_en = 1'b0; sel = 1'b0;
      @(negedge clk);

      // Reset, then idle showing F.
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      // Hex counts down through wrap, shown every clock on instance 0.
      for (int i = 0; i < 40; i++) step(0, 1, 0, 0);
      // BCD on instance 1 steps every 4 clocks, hex holds.
      step(1, 0, 0, 1);
      for (int i = 0; i < 50; i++) step(0, 0, 1, 1);
      // Both enabled, sel toggles every 5 clocks.
      for (int i = 0; i < 40; i++) step(0, 1, 1, ((i / 5) % 2) == 1);

      // Randomized: occasional reset, enable changes, sel flips.
      h = 1'b1; b = 1'b1; s = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            h = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 4) == 0) s = ~s;
         step(($urandom_range(0, 59) == 0), h, b, s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
